// File: rtl/arb_conv_32_8_if.sv
// Handshake bundle between the two word sources, the arbiter and the 32-to-8 serializer.
// master = source/serializer side (the environment), slave = the arbiter.
interface arb_conv_32_8_if;
  logic        req_a;
  logic [31:0] data_a;
  logic        ack_a;
  logic        req_b;
  logic [31:0] data_b;
  logic        ack_b;
  logic        conv_valid;
  logic [31:0] conv_data;
  logic        gnt_id;
  logic        busy;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, conv_valid, conv_data, gnt_id, busy
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, conv_valid, conv_data, gnt_id, busy
  );
endinterface

// File: rtl/arb_conv_32_8.sv
// Round-robin arbiter feeding one 32-to-8 serializer from two word sources.
// Each captured word is held on conv_data with conv_valid high for exactly 4 beats.
//
// state | meaning
// IDLE  | no word in flight, conv_valid low, capture on any enabled request
// SEND  | word held for beats 0..3; beat 3 may capture the next word back-to-back
module arb_conv_32_8 #(
  parameter bit FIRST_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             en,
  arb_conv_32_8_if.slave   bus,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [1:0]       beat, beat_nxt;
  logic             last_gnt, last_nxt;
  logic             valid_q, valid_nxt;
  logic [31:0]      data_q, data_nxt;
  logic             gnt_q, gnt_nxt;
  logic             ack_a_q, ack_a_nxt;
  logic             ack_b_q, ack_b_nxt;
  logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;

  logic word_end;
  logic capture;
  logic win;

  assign word_end = (state == SEND) && (beat == 2'd3);
  assign capture  = en && (bus.req_a || bus.req_b) && ((state == IDLE) || word_end);
  // On a tie the source that did not win last time gets the word.
  assign win      = (bus.req_a && bus.req_b) ? ~last_gnt : bus.req_b;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      beat     <= 2'd0;
      last_gnt <= ~FIRST_PRIO;
      valid_q  <= 1'b0;
      data_q   <= 32'd0;
      gnt_q    <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      last_gnt <= last_nxt;
      valid_q  <= valid_nxt;
      data_q   <= data_nxt;
      gnt_q    <= gnt_nxt;
      ack_a_q  <= ack_a_nxt;
      ack_b_q  <= ack_b_nxt;
      cnt_a    <= cnt_a_nxt;
      cnt_b    <= cnt_b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    last_nxt  = last_gnt;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    gnt_nxt   = gnt_q;
    ack_a_nxt = 1'b0;
    ack_b_nxt = 1'b0;
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;

    // The finishing word is counted even when the next one is captured on the same edge.
    if (word_end) begin
      if (gnt_q) cnt_b_nxt = cnt_b + 1'b1;
      else       cnt_a_nxt = cnt_a + 1'b1;
    end

    if (capture) begin
      state_nxt = SEND;
      beat_nxt  = 2'd0;
      valid_nxt = 1'b1;
      data_nxt  = win ? bus.data_b : bus.data_a;
      gnt_nxt   = win;
      last_nxt  = win;
      ack_a_nxt = ~win;
      ack_b_nxt = win;
    end else if (word_end) begin
      state_nxt = IDLE;
      beat_nxt  = 2'd0;
      valid_nxt = 1'b0;
    end else if (state == SEND) begin
      beat_nxt  = beat + 2'd1;
    end
  end

  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.conv_valid = valid_q;
  assign bus.conv_data  = data_q;
  assign bus.gnt_id     = gnt_q;
  assign bus.busy       = valid_q;

endmodule
